wb_ram_burst: RTL and testbench

Parametrised Wishbone B4 slave RAM with registered-feedback burst support. It is the generalised successor of the fixed 8-bit x 2k RAM, with configurable data width, depth, byte-lane selects, incrementing and wrapping bursts, and an error response for out-of-range accesses. It sits on the shared Wishbone bus as scratch or buffer memory for masters and testbench masters.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_ram_bank.sv | 38 +++
 rtl/wb_ram_burst.sv | 124 ++++++++++++
 tb/tb_wb_ram_burst.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions: cycle/burst type codes and the burst
// address sequencing rule used by both the RAM slave and bus master models.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Address of the beat following 'addr'. Linear bursts simply increment;
  // the caller truncates to its own address width, which gives the modulo
  // wrap at the top of the address space. Wrapping bursts only advance the
  // low bits so the burst stays inside its aligned 4/8/16-word block.
  function automatic logic [31:0] wb_next_addr(input logic [31:0] addr,
                                               input logic [1:0]  bte);
    logic [31:0] nxt;
    case (bte)
      BTE_LINEAR: nxt = addr + 32'd1;
      BTE_WRAP4:  nxt = {addr[31:2], addr[1:0] + 2'd1};
      BTE_WRAP8:  nxt = {addr[31:3], addr[2:0] + 3'd1};
      BTE_WRAP16: nxt = {addr[31:4], addr[3:0] + 4'd1};
      default:    nxt = addr + 32'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_ram_bank.sv
// Single-port RAM array with per-byte write enables and a registered read
// port; written so that synthesis maps it onto block RAM.
module wb_ram_bank #(
  parameter int DW        = 32,
  parameter int AW        = 11,
  parameter int MEM_WORDS = 2**AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [DW/8-1:0] sel,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_WORDS);

  logic [DW-1:0] mem [0:MEM_WORDS-1];
  logic [IW-1:0] idx;
  logic          hit;

  // Upper address bits only matter for the range guard; the array itself
  // is indexed with just enough bits to cover MEM_WORDS.
  assign idx = addr[IW-1:0];
  assign hit = ({1'b0, addr} < LIMIT);

  // Byte-lane write plus read-before-write registered output.
  always_ff @(posedge clk) begin
    if (we && hit) begin
      for (int b = 0; b < DW/8; b++) begin
        if (sel[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone B4 RAM slave with registered-feedback bursts. The control FSM
// issues ack/err one cycle after the request is taken; during a read burst
// the next beat's address is predicted so data lands together with its ack.
module wb_ram_burst
  import wb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 11,
  parameter int MEM_WORDS = 2**AW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   data_i,
  input  logic            we_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [2:0]      cti_i,
  input  logic [1:0]      bte_i,
  output logic            ack_o,
  output logic            err_o,
  output logic [DW-1:0]   data_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CLASSIC = 2'd1;
  localparam logic [1:0] ST_BURST   = 2'd2;

  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_WORDS);

  logic [1:0]    state;
  logic [AW-1:0] nxt_addr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;
  logic          req;
  logic          cur_ok;
  logic          nxt_ok;
  logic          ram_we;

  // A beat that was just terminated (ack or err) is not a new request.
  assign req      = cyc_i & stb_i & ~ack_o & ~err_o;
  assign nxt_addr = AW'(wb_next_addr(32'(addr_i), bte_i));
  assign cur_ok   = ({1'b0, addr_i}   < LIMIT);
  assign nxt_ok   = ({1'b0, nxt_addr} < LIMIT);

  // The write lands at the end of the acked cycle with the master's
  // current address, so the array is always addressed by addr_i for
  // writes; reads fetch the predicted beat once a burst is streaming.
  assign ram_we   = cyc_i & stb_i & we_i & ack_o & cur_ok;
  assign ram_addr = (!we_i && state == ST_BURST && ack_o) ? nxt_addr : addr_i;

  // Read data is only presented during an ack; zero otherwise (incl. err).
  assign data_o   = ack_o ? ram_q : '0;

  wb_ram_bank #(
    .DW        (DW),
    .AW        (AW),
    .MEM_WORDS (MEM_WORDS)
  ) u_bank (
    .clk   (clk_i),
    .we    (ram_we),
    .sel   (sel_i),
    .addr  (ram_addr),
    .wdata (data_i),
    .rdata (ram_q)
  );

  // Access FSM with ack/err generation and range checking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (!cyc_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req) state <= (cti_i == CTI_INCR) ? ST_BURST : ST_CLASSIC;
          end
          ST_CLASSIC: begin
            state <= ST_IDLE;
            if (stb_i) begin
              if (cur_ok) ack_o <= 1'b1;
              else        err_o <= 1'b1;
            end
          end
          ST_BURST: begin
            if (!stb_i) begin
              // Master wait state: drop out, the next strobe starts afresh.
              state <= ST_IDLE;
            end else if (!ack_o) begin
              // First beat: check the address the master is presenting.
              if (cur_ok) ack_o <= 1'b1;
              else begin
                err_o <= 1'b1;
                state <= ST_IDLE;
              end
            end else begin
              case (cti_i)
                CTI_INCR: begin
                  if (nxt_ok) ack_o <= 1'b1;
                  else begin
                    err_o <= 1'b1;
                    state <= ST_IDLE;
                  end
                end
                CTI_EOB: state <= ST_IDLE;
                // Classic or reserved codes make the acked beat the last one.
                default: state <= ST_IDLE;
              endcase
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_burst.sv
// Bench for wb_ram_burst: a full-depth instance and a MEM_WORDS=1000
// instance share one bus; tasks act as the Wishbone master.
module tb_wb_ram_burst;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr;
  logic [31:0] wdat;
  logic        we, cyc, stb;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack_a, err_a, ack_b, err_b;
  logic [31:0] dat_a, dat_b;

  always #5 clk = ~clk;

  wb_ram_burst #(.DW(32), .AW(11)) dut_a (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdat), .we_i(we),
    .cyc_i(cyc), .stb_i(stb), .sel_i(sel), .cti_i(cti), .bte_i(bte),
    .ack_o(ack_a), .err_o(err_a), .data_o(dat_a));

  wb_ram_burst #(.DW(32), .AW(11), .MEM_WORDS(1000)) dut_b (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdat), .we_i(we),
    .cyc_i(cyc), .stb_i(stb), .sel_i(sel), .cti_i(cti), .bte_i(bte),
    .ack_o(ack_b), .err_o(err_b), .data_o(dat_b));

  int checks = 0;
  int errors = 0;
  bit use_b = 1'b0;

  logic [31:0] model [0:2047];
  logic [31:0] bdata [0:15];
  logic [3:0]  bsel  [0:15];
  logic [31:0] bexp  [0:15];

  typedef struct {
    bit          w;
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(output logic a, output logic e, output logic [31:0] d);
    if (use_b) begin a = ack_b; e = err_b; d = dat_b; end
    else       begin a = ack_a; e = err_a; d = dat_a; end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Burst address sequence from the block-size arithmetic.
  function automatic logic [10:0] next_beat(input logic [10:0] a, input logic [1:0] b);
    int ai, w, r;
    ai = int'(a);
    w  = (b == BTE_WRAP4) ? 4 : (b == BTE_WRAP8) ? 8 : (b == BTE_WRAP16) ? 16 : 0;
    if (w == 0) r = (ai + 1) % 2048;
    else        r = (ai / w) * w + ((ai % w) + 1) % w;
    return 11'(r);
  endfunction

  task automatic classic(input bit w, input logic [10:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit exp_err, output logic [31:0] rd);
    logic ak, er;
    logic [31:0] dd;
    int lat;
    cyc = 1; stb = 1; we = w; addr = a; wdat = d; sel = s; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    lat = 0;
    do begin
      tick(); lat++; sample(ak, er, dd);
    end while (!ak && !er && lat < 8);
    chk("classic latency", lat, 2);
    chk("classic ack", 32'(ak), 32'(!exp_err));
    chk("classic err", 32'(er), 32'(exp_err));
    if (er) chk("classic err data", dd, 32'h0);
    rd = dd;
    if (ak && w && !use_b) model[a] = merge(model[a], d, s);
    tick(); sample(ak, er, dd);
    chk("classic term low", {30'h0, ak, er}, 32'h0);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic burst(input bit w, input logic [10:0] start, input int n,
                       input logic [1:0] b, input int err_beat);
    logic ak, er;
    logic [31:0] dd;
    logic [10:0] a;
    int lat;
    a = start;
    cyc = 1; stb = 1; we = w; addr = a; wdat = bdata[0]; sel = bsel[0]; bte = b;
    cti = (n == 1) ? CTI_EOB : CTI_INCR;
    lat = 0;
    do begin
      tick(); lat++; sample(ak, er, dd);
    end while (!ak && !er && lat < 8);
    chk("burst latency", lat, 2);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        tick(); sample(ak, er, dd);
        a = next_beat(a, b);
        addr = a; wdat = bdata[i]; sel = bsel[i];
        cti = (i == n - 1) ? CTI_EOB : CTI_INCR;
      end
      chk($sformatf("burst beat%0d ack", i), 32'(ak), 32'(i != err_beat));
      chk($sformatf("burst beat%0d err", i), 32'(er), 32'(i == err_beat));
      if (er) chk($sformatf("burst beat%0d err data", i), dd, 32'h0);
      else if (!w) chk($sformatf("burst beat%0d data @%h", i, a), dd, bexp[i]);
      if (ak && w && !use_b) model[a] = merge(model[a], bdata[i], bsel[i]);
      if (er || !ak) break;
    end
    tick(); sample(ak, er, dd);
    chk("burst term low", {30'h0, ak, er}, 32'h0);
    cyc = 0; stb = 0; we = 0; cti = CTI_CLASSIC;
  endtask

  // ack and err must never coincide on either instance.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ack_err_excl_a", 32'(ack_a & err_a), 32'h0);
      chk("ack_err_excl_b", 32'(ack_b & err_b), 32'h0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [10:0] a;
    logic ak, er;
    logic [31:0] dd;
    int lat, op, n;
    logic [1:0] b;
    logic [7:0] order [0:7];

    cyc = 0; stb = 0; we = 0; addr = '0; wdat = '0; sel = '0;
    cti = CTI_CLASSIC; bte = BTE_LINEAR;
    for (int i = 0; i < 2048; i++) model[i] = '0;
    for (int i = 0; i < 16; i++) begin bdata[i] = '0; bsel[i] = 4'hF; bexp[i] = '0; end

    tbl[0]  = '{1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 11'h010, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 11'h020, 32'h11223344, 4'hF, 32'h0};
    tbl[3]  = '{1'b1, 11'h020, 32'hAABBCCDD, 4'h5, 32'h0};
    tbl[4]  = '{1'b0, 11'h020, 32'h0,        4'hF, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 11'h030, 32'h01234567, 4'hF, 32'h0};
    tbl[6]  = '{1'b1, 11'h030, 32'hCAFEF00D, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 11'h030, 32'h0,        4'hF, 32'h01234567};
    tbl[8]  = '{1'b1, 11'h040, 32'h00000000, 4'hF, 32'h0};
    tbl[9]  = '{1'b1, 11'h040, 32'hA5A5A5A5, 4'hA, 32'h0};
    tbl[10] = '{1'b0, 11'h040, 32'h0,        4'hF, 32'hA500A500};
    tbl[11] = '{1'b1, 11'h050, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[12] = '{1'b0, 11'h050, 32'h0,        4'h3, 32'hFFFFFFFF};

    // Reset state
    tick(); tick();
    chk("reset ack_a", 32'(ack_a), 32'h0);
    chk("reset err_a", 32'(err_a), 32'h0);
    chk("reset data_a", dat_a, 32'h0);
    chk("reset ack_b", 32'(ack_b), 32'h0);
    chk("reset err_b", 32'(err_b), 32'h0);
    chk("reset data_b", dat_b, 32'h0);
    rst = 0;
    tick();

    // Classic accesses, back-to-back
    for (int i = 0; i <= 12; i++) begin
      classic(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, 1'b0, rd);
      if (!tbl[i].w) chk($sformatf("table read %0d", i), rd, tbl[i].exp);
    end

    // Linear burst across the top of the address space
    for (int i = 0; i < 4; i++) begin
      bdata[i] = 32'h7FE0_0000 + 32'(i); bsel[i] = 4'hF; bexp[i] = bdata[i];
    end
    burst(1'b1, 11'h7FE, 4, BTE_LINEAR, -1);
    burst(1'b0, 11'h7FE, 4, BTE_LINEAR, -1);
    classic(1'b0, 11'h000, 32'h0, 4'hF, 1'b0, rd);
    chk("linear wrap word 0", rd, 32'h7FE0_0002);
    classic(1'b0, 11'h001, 32'h0, 4'hF, 1'b0, rd);
    chk("linear wrap word 1", rd, 32'h7FE0_0003);

    // Wrap8 read from 0x0D
    for (int i = 0; i < 8; i++) begin
      bdata[i] = 32'hC0DE_0000 + 32'(8 + i); bsel[i] = 4'hF;
    end
    burst(1'b1, 11'h008, 8, BTE_LINEAR, -1);
    order[0] = 8'h0D; order[1] = 8'h0E; order[2] = 8'h0F; order[3] = 8'h08;
    order[4] = 8'h09; order[5] = 8'h0A; order[6] = 8'h0B; order[7] = 8'h0C;
    for (int i = 0; i < 8; i++) bexp[i] = 32'hC0DE_0000 + 32'(order[i]);
    burst(1'b0, 11'h00D, 8, BTE_WRAP8, -1);

    // Out-of-range on the MEM_WORDS=1000 instance
    tick(); tick();
    use_b = 1'b1;
    classic(1'b1, 11'd1000, 32'h55, 4'hF, 1'b1, rd);
    classic(1'b1, 11'd1040, 32'h55, 4'hF, 1'b1, rd);
    classic(1'b0, 11'h010, 32'h0, 4'hF, 1'b0, rd);
    chk("oor alias untouched", rd, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin bdata[i] = 32'h9980_0000 + 32'(i); bsel[i] = 4'hF; end
    burst(1'b1, 11'd998, 4, BTE_LINEAR, 2);
    tick(); tick();
    classic(1'b0, 11'd998, 32'h0, 4'hF, 1'b0, rd);
    chk("oor burst word 998", rd, 32'h9980_0000);
    classic(1'b0, 11'd999, 32'h0, 4'hF, 1'b0, rd);
    chk("oor burst word 999", rd, 32'h9980_0001);
    classic(1'b0, 11'd1000, 32'h0, 4'hF, 1'b1, rd);
    use_b = 1'b0;
    tick(); tick();

    // Reset in the middle of a write burst
    classic(1'b1, 11'h200, 32'h0BAD_0000, 4'hF, 1'b0, rd);
    classic(1'b1, 11'h201, 32'h0BAD_0001, 4'hF, 1'b0, rd);
    cyc = 1; stb = 1; we = 1; addr = 11'h200; wdat = 32'h600D_0000; sel = 4'hF;
    cti = CTI_INCR; bte = BTE_LINEAR;
    lat = 0;
    do begin
      tick(); lat++; sample(ak, er, dd);
    end while (!ak && !er && lat < 8);
    chk("rst burst latency", lat, 2);
    tick();
    chk("rst burst beat1 ack", 32'(ack_a), 32'h1);
    addr = 11'h201; wdat = 32'h600D_0001;
    #2 rst = 1;
    #1 chk("rst async ack drop", 32'(ack_a), 32'h0);
    chk("rst async data", dat_a, 32'h0);
    @(posedge clk);
    #1 rst = 0; cyc = 0; stb = 0; we = 0; cti = CTI_CLASSIC;
    tick();
    classic(1'b0, 11'h201, 32'h0, 4'hF, 1'b0, rd);
    chk("rst beat1 old data", rd, 32'h0BAD_0001);
    classic(1'b0, 11'h200, 32'h0, 4'hF, 1'b0, rd);
    chk("rst beat0 written", rd, 32'h600D_0000);
    model[11'h200] = 32'h600D_0000;
    model[11'h201] = 32'h0BAD_0001;

    // Randomized traffic in window 0x100..0x13F against the model
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin bdata[i] = $urandom; bsel[i] = 4'hF; end
      burst(1'b1, 11'(32'h100 + 32'(16 * k)), 16, BTE_LINEAR, -1);
    end
    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 3);
      if (op < 2) begin
        a = 11'($urandom_range(32'h100, 32'h13F));
        if (op == 0) classic(1'b1, a, $urandom, 4'($urandom_range(0, 15)), 1'b0, rd);
        else begin
          classic(1'b0, a, 32'h0, 4'($urandom_range(0, 15)), 1'b0, rd);
          chk($sformatf("random read @%h", a), rd, model[a]);
        end
      end else begin
        b = 2'($urandom_range(0, 3));
        n = $urandom_range(1, 8);
        if (b == BTE_LINEAR) a = 11'($urandom_range(32'h100, 32'h140 - 32'(n)));
        else                 a = 11'($urandom_range(32'h100, 32'h13F));
        for (int i = 0; i < 16; i++) begin
          bdata[i] = $urandom; bsel[i] = 4'($urandom_range(0, 15));
        end
        begin
          logic [10:0] p;
          p = a;
          for (int i = 0; i < n; i++) begin bexp[i] = model[p]; p = next_beat(p, b); end
        end
        burst(op == 2, a, n, b, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
